// File: rtl/regfile_wr_arbiter_if.sv
// Writeback request ports (A and B) plus the registered register-file write port.
// No storage and no latency; a_ready/b_ready are the backpressure signals.
// Each requester holds rd/data stable while its valid is high and ready is low.
interface regfile_wr_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            reg_write;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            b_forced;

    // Requesters and register-file observer side.
    modport master (
        output a_valid, a_rd, a_data,
        output b_valid, b_rd, b_data,
        input  a_ready, b_ready,
        input  reg_write, rd_addr, rd_data, b_forced
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_rd, a_data,
        input  b_valid, b_rd, b_data,
        output a_ready, b_ready,
        output reg_write, rd_addr, rd_data, b_forced
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-source register-file write arbiter: A favoured, B forced ahead after STARVE_LIMIT lost cycles.
// Latency: one cycle from the accept edge to the registered write; readies are combinational.
// Backpressure: only one ready per cycle, both low in reset; the loser holds its request.
module regfile_wr_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_wr_arbiter_if.slave bus
);
    typedef enum logic {
        PRIO_A  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wr_req_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;

    wr_req_t a_req;
    wr_req_t b_req;
    wr_req_t win_req;
    logic    a_gnt;
    logic    b_gnt;
    logic    xfer;
    logic    b_wait;

    logic            reg_write_q;
    logic [4:0]      rd_addr_q;
    logic [XLEN-1:0] rd_data_q;

    assign a_req = '{rd: bus.a_rd, data: bus.a_data};
    assign b_req = '{rd: bus.b_rd, data: bus.b_data};

    // A lone requester always wins; on contention the state picks the winner.
    assign a_gnt = reset_n && bus.a_valid && !(bus.b_valid && (state == FORCE_B));
    assign b_gnt = reset_n && bus.b_valid && !(bus.a_valid && (state == PRIO_A));

    assign xfer    = a_gnt || b_gnt;
    assign win_req = a_gnt ? a_req : b_req;
    assign b_wait  = bus.b_valid && !b_gnt;

    assign cnt_inc = (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    assign cnt_hit = (cnt_inc >= LIMIT_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= PRIO_A;
            starve_cnt <= '0;
        end else begin
            case (state)
                PRIO_A: begin
                    if (b_gnt) begin
                        starve_cnt <= '0;
                    end else if (b_wait) begin
                        starve_cnt <= cnt_inc;
                        if (cnt_hit) begin
                            state <= FORCE_B;
                        end
                    end
                end
                FORCE_B: begin
                    // Stay here until B actually transfers, even if b_valid is low.
                    if (b_gnt) begin
                        state      <= PRIO_A;
                        starve_cnt <= '0;
                    end
                end
                default: begin
                    state      <= PRIO_A;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    // x0 requests are consumed but never raise the write enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_write_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            reg_write_q <= xfer && (win_req.rd != 5'd0);
            if (xfer) begin
                rd_addr_q <= win_req.rd;
                rd_data_q <= win_req.data;
            end
        end
    end

    assign bus.a_ready   = a_gnt;
    assign bus.b_ready   = b_gnt;
    assign bus.reg_write = reg_write_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.b_forced  = (state == FORCE_B);

    a_one_grant: assert property (@(posedge clk) disable iff (!reset_n) !(a_gnt && b_gnt));
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed cases plus randomized traffic against a transaction model.
module tb_regfile_wr_arbiter;
    localparam int XLEN  = 32;
    localparam int LIMIT = 4;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.XLEN(XLEN)) bus ();

    regfile_wr_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int              cyc;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   cyc    = 0;
    int   b_lost = 0;   // cycles B has lost since its last transfer
    int   mode   = 0;   // 0 random, 1 contention, 2 idle after accept

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [4:0] pick_rd();
        int r;
        r = $urandom_range(0, 9);
        if (mode == 1) return 5'($urandom_range(1, 31));
        if (r == 0) return 5'd0;
        if (r < 3) return 5'd7;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic new_a();
        bus.a_valid = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
        bus.a_rd    = pick_rd();
        bus.a_data  = $urandom;
    endtask

    task automatic new_b();
        bus.b_valid = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        bus.b_rd    = pick_rd();
        bus.b_data  = $urandom;
    endtask

    // One cycle: predict the grant, check readies, queue the expected write, then refresh drivers.
    task automatic step();
        logic av, bv, forced, ga, gb;
        @(negedge clk);
        av     = bus.a_valid;
        bv     = bus.b_valid;
        forced = (b_lost >= LIMIT);
        ga     = av && !(bv && forced);
        gb     = bv && !ga;
        check("a_ready", 64'(bus.a_ready), 64'(ga));
        check("b_ready", 64'(bus.b_ready), 64'(gb));
        check("b_forced", 64'(bus.b_forced), 64'(forced));
        if (ga && bus.a_rd != 5'd0) sb.push_back('{cyc + 1, bus.a_rd, bus.a_data});
        if (gb && bus.b_rd != 5'd0) sb.push_back('{cyc + 1, bus.b_rd, bus.b_data});
        if (gb) b_lost = 0;
        else if (bv && b_lost < 7) b_lost++;
        @(posedge clk);
        #1;
        cyc++;
        if (ga || !av) new_a();
        if (gb || !bv) new_b();
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write and its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.reg_write) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got rd %0d data %0h expected no write (cycle %0d)",
                                 bus.rd_addr, bus.rd_data, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("write_cycle", 64'(cyc), 64'(e.cyc));
                        check("rd_addr", 64'(bus.rd_addr), 64'(e.rd));
                        check("rd_data", 64'(bus.rd_data), 64'(e.data));
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missing_write: got reg_write 0 expected rd %0d data %0h (cycle %0d)",
                             sb[0].rd, sb[0].data, cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bool_dummy();
    end

    task automatic bool_dummy();
        int guard;
        // Reset with both requesters active.
        bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h1111_1111;
        bus.b_valid = 1'b1; bus.b_rd = 5'd4; bus.b_data = 32'h2222_2222;
        repeat (3) @(posedge clk);
        #2;
        check("reset_reg_write", 64'(bus.reg_write), 64'd0);
        check("reset_a_ready", 64'(bus.a_ready), 64'd0);
        check("reset_b_ready", 64'(bus.b_ready), 64'd0);
        check("reset_b_forced", 64'(bus.b_forced), 64'd0);
        check("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Only A.
        mode = 2;
        bus.a_valid = 1'b1; bus.a_rd = 5'd5; bus.a_data = 32'hDEAD_BEEF;
        repeat (3) step();

        // B to x0: accepted, no write.
        bus.b_valid = 1'b1; bus.b_rd = 5'd0; bus.b_data = 32'h0000_1234;
        repeat (3) step();

        // Same rd on both ports: A then B on consecutive cycles.
        bus.a_valid = 1'b1; bus.a_rd = 5'd7; bus.a_data = 32'd1;
        bus.b_valid = 1'b1; bus.b_rd = 5'd7; bus.b_data = 32'd2;
        repeat (4) step();

        // Sustained contention: A,A,A,A,B pattern.
        mode = 1;
        new_a();
        new_b();
        repeat (20) step();

        // Random traffic.
        mode = 0;
        repeat (400) step();

        // Drive into FORCE_B with a write in flight, then reset asynchronously.
        mode = 1;
        new_a();
        new_b();
        guard = 0;
        while (!(b_lost >= LIMIT && bus.reg_write) && guard < 20) begin
            step();
            guard++;
        end
        check("reach_force_b", 64'(guard < 20), 64'd1);
        #2;
        check("inflight_b_forced", 64'(bus.b_forced), 64'(b_lost >= LIMIT));
        check("inflight_reg_write", 64'(bus.reg_write), 64'd1);
        reset_n = 1'b0;
        #1;
        check("async_reg_write", 64'(bus.reg_write), 64'd0);
        check("async_b_forced", 64'(bus.b_forced), 64'd0);
        check("async_a_ready", 64'(bus.a_ready), 64'd0);
        check("async_b_ready", 64'(bus.b_ready), 64'd0);
        sb.delete();
        b_lost = 0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        new_a();
        new_b();
        repeat (12) step();

        // Drain and confirm every expected write appeared.
        mode = 2;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        repeat (3) step();
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask
endmodule
